// File: rtl/hcs_pkg.sv
// Shared types and constants for the multi-channel patient monitor.
// Holds the FSM state encoding, flag bit positions and default normal limits.
// No ports; imported by hcs_channel_check and multi_patient_monitor.
package hcs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Bit positions inside the 3-bit {temp, pH, pressure} flag vector.
  localparam int FLAG_PRESS = 0;
  localparam int FLAG_PH    = 1;
  localparam int FLAG_TEMP  = 2;

  // Default inclusive normal limits.
  localparam int DEF_PRESS_LO = 10;
  localparam int DEF_PRESS_HI = 50;
  localparam int DEF_PH_LO    = 6;
  localparam int DEF_PH_HI    = 9;
  localparam int DEF_TEMP_HI  = 100;

endpackage

// File: rtl/hcs_channel_check.sv
// Purpose : threshold compare of one channel sample against inclusive limits.
// Latency : purely combinational, zero cycles.
// Backpres: none; flags follow the inputs directly.
// Ports   : pressure/ph/temp in; flags {temp,pH,pressure} and abnormal (any flag) out.
module hcs_channel_check
  import hcs_pkg::*;
#(
  parameter int PRESS_W  = 6,
  parameter int PRESS_LO = DEF_PRESS_LO,
  parameter int PRESS_HI = DEF_PRESS_HI,
  parameter int PH_LO    = DEF_PH_LO,
  parameter int PH_HI    = DEF_PH_HI,
  parameter int TEMP_HI  = DEF_TEMP_HI
) (
  input  logic [PRESS_W-1:0] pressure,
  input  logic [3:0]         ph,
  input  logic [7:0]         temp,
  output logic [2:0]         flags,
  output logic               abnormal
);

  localparam logic [PRESS_W-1:0] P_LO = PRESS_W'(PRESS_LO);
  localparam logic [PRESS_W-1:0] P_HI = PRESS_W'(PRESS_HI);
  localparam logic [3:0]         H_LO = 4'(PH_LO);
  localparam logic [3:0]         H_HI = 4'(PH_HI);
  localparam logic [7:0]         T_HI = 8'(TEMP_HI);

  always_comb begin
    flags             = '0;
    flags[FLAG_PRESS] = (pressure < P_LO) || (pressure > P_HI);
    flags[FLAG_PH]    = (ph < H_LO) || (ph > H_HI);
    flags[FLAG_TEMP]  = (temp > T_HI);
    abnormal          = |flags;
  end

endmodule

// File: rtl/multi_patient_monitor.sv
// Purpose : snapshot all patient channels on request, scan them one per cycle,
//           track per-channel persistence and present warnings one at a time.
// Latency : NUM_CH scan cycles after the request edge, then REPORT or IDLE.
// Backpres: request ignored while busy; each warning held until confirm.
// Ports   : clock/reset (sync, active-high), request, confirm, packed channel
//           inputs; busy, warn_valid/warn_ch/warn_vector, abnormal_mask.
// Option  : define HCS_EVENT_STATS_EN to add the 16-bit event_count output.
module multi_patient_monitor
  import hcs_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PRESS_W  = 6,
  parameter int PERSIST  = 3,
  parameter int PRESS_LO = DEF_PRESS_LO,
  parameter int PRESS_HI = DEF_PRESS_HI,
  parameter int PH_LO    = DEF_PH_LO,
  parameter int PH_HI    = DEF_PH_HI,
  parameter int TEMP_HI  = DEF_TEMP_HI
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        request,
  input  logic                        confirm,
  input  logic [NUM_CH*PRESS_W-1:0]   ch_pressure,
  input  logic [NUM_CH*4-1:0]         ch_ph,
  input  logic [NUM_CH*8-1:0]         ch_temp,
  output logic                        busy,
  output logic                        warn_valid,
  output logic [$clog2(NUM_CH)-1:0]   warn_ch,
  output logic [2:0]                  warn_vector,
  output logic [NUM_CH-1:0]           abnormal_mask
`ifdef HCS_EVENT_STATS_EN
  ,
  output logic [15:0]                 event_count
`endif
);

  localparam int               IDX_W    = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [3:0]       CNT_SAT  = 4'(PERSIST);
  localparam logic [3:0]       CNT_ARM  = 4'(PERSIST - 1);

  state_t state, state_nxt;

  logic [IDX_W-1:0]   idx;
  logic [PRESS_W-1:0] snap_press [NUM_CH];
  logic [3:0]         snap_ph    [NUM_CH];
  logic [7:0]         snap_temp  [NUM_CH];
  logic [3:0]         cnt        [NUM_CH];
  logic [2:0]         flags_st   [NUM_CH];
  logic [NUM_CH-1:0]  pending;

  logic [2:0]         cur_flags;
  logic               cur_abn;
  logic               arm;
  logic               last_ch;
  logic [NUM_CH-1:0]  idx_onehot;
  logic [NUM_CH-1:0]  sel_onehot;
  logic [NUM_CH-1:0]  pending_scan;
  logic [IDX_W-1:0]   sel_ch;

  // Single checker shared by all channels; the snapshot is muxed by idx.
  hcs_channel_check #(
    .PRESS_W  (PRESS_W),
    .PRESS_LO (PRESS_LO),
    .PRESS_HI (PRESS_HI),
    .PH_LO    (PH_LO),
    .PH_HI    (PH_HI),
    .TEMP_HI  (TEMP_HI)
  ) u_check (
    .pressure (snap_press[idx]),
    .ph       (snap_ph[idx]),
    .temp     (snap_temp[idx]),
    .flags    (cur_flags),
    .abnormal (cur_abn)
  );

  // A warning arms only on the PERSIST-1 -> PERSIST transition, so a
  // channel that stays abnormal after saturating does not re-arm.
  assign arm          = (state == SCAN) && cur_abn && (cnt[idx] == CNT_ARM);
  assign last_ch      = (idx == LAST_IDX);
  assign idx_onehot   = NUM_CH'(1) << idx;
  assign sel_onehot   = NUM_CH'(1) << sel_ch;
  assign pending_scan = pending | (arm ? idx_onehot : '0);

  // Lowest-index pending channel wins presentation.
  always_comb begin
    sel_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) sel_ch = IDX_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (request) state_nxt = SCAN;
      SCAN:    if (last_ch) state_nxt = (pending_scan != '0) ? REPORT : IDLE;
      REPORT:  if (confirm && ((pending & ~sel_onehot) == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx           <= '0;
      pending       <= '0;
      abnormal_mask <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_press[i] <= '0;
        snap_ph[i]    <= '0;
        snap_temp[i]  <= '0;
        cnt[i]        <= '0;
        flags_st[i]   <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (request) begin
            idx <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
              snap_press[i] <= ch_pressure[i*PRESS_W +: PRESS_W];
              snap_ph[i]    <= ch_ph[i*4 +: 4];
              snap_temp[i]  <= ch_temp[i*8 +: 8];
            end
          end
        end
        SCAN: begin
          abnormal_mask[idx] <= cur_abn;
          if (!cur_abn)                 cnt[idx] <= '0;
          else if (cnt[idx] != CNT_SAT) cnt[idx] <= cnt[idx] + 4'd1;
          if (arm) begin
            pending[idx]  <= 1'b1;
            flags_st[idx] <= cur_flags;
          end
          idx <= last_ch ? '0 : idx + IDX_W'(1);
        end
        REPORT: begin
          if (confirm) pending[sel_ch] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef HCS_EVENT_STATS_EN
  always_ff @(posedge clock) begin
    if (reset)                              event_count <= '0;
    else if (arm && event_count != 16'hFFFF) event_count <= event_count + 16'd1;
  end
`endif

  assign busy        = (state != IDLE);
  assign warn_valid  = (state == REPORT);
  assign warn_ch     = warn_valid ? sel_ch : '0;
  assign warn_vector = warn_valid ? flags_st[sel_ch] : 3'b000;

endmodule

// File: tb/tb_multi_patient_monitor.sv
// Directed bench for multi_patient_monitor with default parameters.
// A reference model of the limits and persistence counters queues the expected
// warnings when each request is driven; they are popped as the DUT presents them.
module tb_multi_patient_monitor;

  localparam int NCH = 4;
  localparam int PW  = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             request;
  logic             confirm;
  logic [NCH*PW-1:0] ch_pressure;
  logic [NCH*4-1:0]  ch_ph;
  logic [NCH*8-1:0]  ch_temp;
  logic             busy;
  logic             warn_valid;
  logic [1:0]       warn_ch;
  logic [2:0]       warn_vector;
  logic [NCH-1:0]   abnormal_mask;
`ifdef HCS_EVENT_STATS_EN
  logic [15:0]      event_count;
`endif

  multi_patient_monitor dut (
    .clock         (clock),
    .reset         (reset),
    .request       (request),
    .confirm       (confirm),
    .ch_pressure   (ch_pressure),
    .ch_ph         (ch_ph),
    .ch_temp       (ch_temp),
    .busy          (busy),
    .warn_valid    (warn_valid),
    .warn_ch       (warn_ch),
    .warn_vector   (warn_vector),
    .abnormal_mask (abnormal_mask)
`ifdef HCS_EVENT_STATS_EN
    ,
    .event_count   (event_count)
`endif
  );

  always #5 clock = ~clock;

  int p   [NCH];
  int phv [NCH];
  int tv  [NCH];
  int mcnt[NCH];

  typedef struct {
    int         ch;
    logic [2:0] vec;
  } warn_t;

  warn_t q[$];

  int checks   = 0;
  int failures = 0;

  always_comb begin
    ch_pressure = '0;
    ch_ph       = '0;
    ch_temp     = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_pressure[i*PW +: PW] = PW'(p[i]);
      ch_ph[i*4 +: 4]         = 4'(phv[i]);
      ch_temp[i*8 +: 8]       = 8'(tv[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_normal();
    for (int i = 0; i < NCH; i++) begin
      p[i]   = 30;
      phv[i] = 7;
      tv[i]  = 90;
    end
  endtask

  // Reference model: limits written straight from the normal ranges,
  // persistence threshold 3, warnings queued in channel order.
  task automatic model_scan(output logic [3:0] mmask);
    for (int i = 0; i < NCH; i++) begin
      logic [2:0] f;
      f[0] = (p[i] < 10) || (p[i] > 50);
      f[1] = (phv[i] < 6) || (phv[i] > 9);
      f[2] = (tv[i] > 100);
      mmask[i] = (f != 3'b000);
      if (mmask[i]) begin
        if (mcnt[i] == 2) q.push_back('{ch: i, vec: f});
        if (mcnt[i] < 3) mcnt[i]++;
      end else begin
        mcnt[i] = 0;
      end
    end
  endtask

  // One full request; optionally pulses request+confirm mid-scan.
  task automatic scan(input bit poke);
    logic [3:0] mmask;
    bit         exp_warn;
    model_scan(mmask);
    exp_warn = (q.size() != 0);
    request = 1'b1;
    @(negedge clock);
    request = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      check("scan_busy", 32'(busy), 1);
      check("scan_no_warn", 32'(warn_valid), 0);
      if (poke && k == 2) begin
        request = 1'b1;
        confirm = 1'b1;
      end
      @(negedge clock);
      request = 1'b0;
      confirm = 1'b0;
    end
    check("end_busy", 32'(busy), 32'(exp_warn));
    check("end_warn_valid", 32'(warn_valid), 32'(exp_warn));
    check("abnormal_mask", 32'(abnormal_mask), 32'(mmask));
  endtask

  // Drain expected warnings, confirming each; then expect idle outputs.
  task automatic service();
    warn_t e;
    while (q.size() != 0) begin
      e = q.pop_front();
      check("warn_valid", 32'(warn_valid), 1);
      check("warn_ch", 32'(warn_ch), 32'(e.ch));
      check("warn_vector", 32'(warn_vector), 32'(e.vec));
      confirm = 1'b1;
      @(negedge clock);
      confirm = 1'b0;
    end
    check("idle_busy", 32'(busy), 0);
    check("idle_warn_valid", 32'(warn_valid), 0);
    check("idle_warn_ch", 32'(warn_ch), 0);
    check("idle_warn_vector", 32'(warn_vector), 0);
  endtask

  initial begin
    reset   = 1'b1;
    request = 1'b0;
    confirm = 1'b0;
    set_normal();
    for (int i = 0; i < NCH; i++) mcnt[i] = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_warn_valid", 32'(warn_valid), 0);
    check("rst_warn_ch", 32'(warn_ch), 0);
    check("rst_warn_vector", 32'(warn_vector), 0);
    check("rst_mask", 32'(abnormal_mask), 0);

    // All channels normal: busy for NUM_CH cycles, no warning
    scan(1'b0);
    service();

    // Channel 2 high pressure on three requests, then a fourth that must not re-arm
    p[2] = 60;
    repeat (3) scan(1'b0);
    service();
    scan(1'b0);
    service();
    set_normal();
    scan(1'b0);
    service();

    // Channel 1 pH and channel 3 temp; request/confirm poked during the last scan
    phv[1] = 10;
    tv[3]  = 120;
    scan(1'b0);
    scan(1'b0);
    scan(1'b1);
    service();
    set_normal();
    scan(1'b0);
    service();

    // Channel 0: abnormal, abnormal, clean, abnormal x3 -> warns only on the last
    p[0] = 5;
    scan(1'b0);
    scan(1'b0);
    p[0] = 30;
    scan(1'b0);
    p[0] = 5;
    scan(1'b0);
    service();
    scan(1'b0);
    service();
    scan(1'b0);
    service();

    // Reset on the second SCAN cycle discards the scan
    request = 1'b1;
    @(negedge clock);
    request = 1'b0;
    check("pre_rst_busy", 32'(busy), 1);
    @(negedge clock);
    check("pre_rst_mask0", 32'(abnormal_mask[0]), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_mask", 32'(abnormal_mask), 0);
    check("mid_rst_warn_valid", 32'(warn_valid), 0);
    for (int i = 0; i < NCH; i++) mcnt[i] = 0;
    q.delete();

    // Following requests accepted; counters restart from zero after reset
    scan(1'b0);
    service();
    scan(1'b0);
    service();
    scan(1'b0);
    service();
    set_normal();
    scan(1'b0);
    service();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
